// File: rtl/i_cache_dm_pkg.sv
// -----------------------------------------------------------------------------
// i_cache_dm_pkg
//   Shared definitions for the direct-mapped instruction cache:
//   - FSM state encoding used by the controller and its debug print
//   - default address/index geometry and a helper that derives the tag width
// -----------------------------------------------------------------------------
package i_cache_dm_pkg;

  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_ADDRESS_BITS = 32;
  localparam int DEF_INDEX_BITS   = 6;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FILL_REQ  = 3'd1,
    FILL_WAIT = 3'd2,
    RESPOND   = 3'd3,
    FLUSH     = 3'd4
  } state_t;

  // Everything above the index field is tag.
  function automatic int tag_bits(input int address_bits, input int index_bits);
    return address_bits - index_bits;
  endfunction

endpackage

// File: rtl/i_cache_dm_array.sv
// -----------------------------------------------------------------------------
// i_cache_dm_array
//   Line storage for the direct-mapped cache: one data word, one tag and one
//   valid bit per line.
//   Ports:
//     clock, reset               clock / async active-high reset (valid bits only)
//     rd_index -> rd_data,
//                 rd_tag,
//                 rd_valid       combinational read port
//     wr_en, wr_index,
//     wr_data, wr_tag            fill port: writes data+tag and sets valid
//     inv_en, inv_index          clears a single valid bit
// -----------------------------------------------------------------------------
module i_cache_dm_array #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_BITS   = 26,
  parameter int INDEX_BITS = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic                  rd_valid,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic                  inv_en,
  input  logic [INDEX_BITS-1:0] inv_index
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [DATA_WIDTH-1:0] data_mem [LINES];
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [LINES-1:0]      valid_q;

  // NOTE: data/tag arrays carry no reset so they map onto plain RAM; the
  // valid bits alone decide whether their contents mean anything.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      data_mem[wr_index] <= wr_data;
      tag_mem[wr_index]  <= wr_tag;
    end
  end

  // Fill and invalidate never coincide (different FSM states); invalidate
  // is written last so it would win regardless.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      if (wr_en)  valid_q[wr_index]  <= 1'b1;
      if (inv_en) valid_q[inv_index] <= 1'b0;
    end
  end

  assign rd_data  = data_mem[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_valid = valid_q[rd_index];

endmodule

// File: rtl/i_cache_dm.sv
// -----------------------------------------------------------------------------
// i_cache_dm
//   Direct-mapped, read-only instruction cache, one word per line. Sits
//   transparently between the fetch port (i_mem_*) and backing memory (mem_*).
//   Hits answer on the next cycle; misses fill one word from memory. A flush
//   sweeps the valid bits one line per cycle.
//   Ports:
//     clock, reset                 clock / async active-high reset
//     i_mem_read, i_mem_address_in fetch request (accepted when i_mem_ready)
//     i_mem_data_out,
//     i_mem_address_out,
//     i_mem_valid                  one-cycle response per accepted request
//     i_mem_ready                  IDLE and no flush requested
//     mem_read, mem_address_in     backing-memory request (held until mem_ready)
//     mem_data_out,
//     mem_address_out, mem_valid   backing-memory response
//     mem_ready                    backing memory accepts the request
//     flush                        level-sampled invalidate-all
//     scan                         per-cycle debug print (simulation only)
//   Optional (macro ICACHE_STATS_EN): hit_count / miss_count saturating
//   counters, cleared by reset and at the start of every flush sweep.
// -----------------------------------------------------------------------------
module i_cache_dm
  import i_cache_dm_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int ADDRESS_BITS    = DEF_ADDRESS_BITS,
  parameter int INDEX_BITS      = DEF_INDEX_BITS,
  parameter int SCAN_CYCLES_MIN = 0,
  parameter int SCAN_CYCLES_MAX = 1000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_mem_read,
  input  logic [ADDRESS_BITS-1:0] i_mem_address_in,
  output logic [DATA_WIDTH-1:0]   i_mem_data_out,
  output logic [ADDRESS_BITS-1:0] i_mem_address_out,
  output logic                    i_mem_valid,
  output logic                    i_mem_ready,
  output logic                    mem_read,
  output logic [ADDRESS_BITS-1:0] mem_address_in,
  input  logic [DATA_WIDTH-1:0]   mem_data_out,
  input  logic [ADDRESS_BITS-1:0] mem_address_out,
  input  logic                    mem_valid,
  input  logic                    mem_ready,
  input  logic                    flush,
  input  logic                    scan
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
`endif
);

  localparam int TAG_BITS = tag_bits(ADDRESS_BITS, INDEX_BITS);

  state_t                  state;
  logic [ADDRESS_BITS-1:0] req_addr;
  logic [INDEX_BITS-1:0]   flush_idx;
  logic                    flush_pending;
  logic [31:0]             cycle_count;

  logic [DATA_WIDTH-1:0]   rd_data;
  logic [TAG_BITS-1:0]     rd_tag;
  logic                    rd_valid;
  logic                    hit;
  logic                    accept;
  logic                    fill_match;
  logic                    flush_start;

  i_cache_dm_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .TAG_BITS   (TAG_BITS),
    .INDEX_BITS (INDEX_BITS)
  ) u_array (
    .clock     (clock),
    .reset     (reset),
    .rd_index  (i_mem_address_in[INDEX_BITS-1:0]),
    .rd_data   (rd_data),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .wr_en     (state == FILL_WAIT && fill_match),
    .wr_index  (req_addr[INDEX_BITS-1:0]),
    .wr_data   (mem_data_out),
    .wr_tag    (req_addr[ADDRESS_BITS-1:INDEX_BITS]),
    .inv_en    (state == FLUSH),
    .inv_index (flush_idx)
  );

  assign hit         = rd_valid && (rd_tag == i_mem_address_in[ADDRESS_BITS-1:INDEX_BITS]);
  // Ready is combinational on flush so a same-cycle flush blocks acceptance;
  // gating with reset keeps every output low while reset is held.
  assign i_mem_ready = !reset && (state == IDLE) && !flush;
  assign accept      = i_mem_read && i_mem_ready;
  // Responses for any other address (e.g. one issued before a reset) are dropped.
  assign fill_match  = mem_valid && (mem_address_out == req_addr);
  assign flush_start = (state == IDLE && flush) ||
                       (state == RESPOND && (flush_pending || flush));

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      req_addr          <= '0;
      flush_idx         <= '0;
      flush_pending     <= 1'b0;
      i_mem_valid       <= 1'b0;
      i_mem_data_out    <= '0;
      i_mem_address_out <= '0;
      mem_read          <= 1'b0;
      mem_address_in    <= '0;
    end else begin
      i_mem_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) begin
            state <= FLUSH;
          end else if (accept) begin
            if (hit) begin
              i_mem_valid       <= 1'b1;
              i_mem_data_out    <= rd_data;
              i_mem_address_out <= i_mem_address_in;
            end else begin
              req_addr       <= i_mem_address_in;
              mem_read       <= 1'b1;
              mem_address_in <= i_mem_address_in;
              state          <= FILL_REQ;
            end
          end
        end
        FILL_REQ: begin
          if (flush) flush_pending <= 1'b1;
          if (mem_ready) begin
            mem_read <= 1'b0;
            state    <= FILL_WAIT;
          end
        end
        FILL_WAIT: begin
          if (flush) flush_pending <= 1'b1;
          if (fill_match) begin
            i_mem_valid       <= 1'b1;
            i_mem_data_out    <= mem_data_out;
            i_mem_address_out <= req_addr;
            state             <= RESPOND;
          end
        end
        RESPOND: begin
          flush_pending <= 1'b0;
          state         <= (flush_pending || flush) ? FLUSH : IDLE;
        end
        FLUSH: begin
          flush_idx <= flush_idx + 1'b1;  // wraps back to 0 on the last line
          if (flush_idx == '1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cycle_count <= '0;
    else       cycle_count <= cycle_count + 32'd1;
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (flush_start) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (accept) begin
      if (hit && hit_count != 32'hFFFF_FFFF)        hit_count  <= hit_count + 32'd1;
      else if (!hit && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // Window test done as an offset compare so it behaves with a wrapping counter.
  always @(posedge clock) begin
    if (!reset && scan &&
        (cycle_count - 32'(SCAN_CYCLES_MIN)) <= 32'(SCAN_CYCLES_MAX - SCAN_CYCLES_MIN)) begin
`ifdef ICACHE_STATS_EN
      $display("[i_cache_dm] cyc=%0d state=%s addr=%h hit=%b flush_idx=%0d hits=%0d misses=%0d flush_start=%b",
               cycle_count, state.name(), i_mem_address_in, hit, flush_idx,
               hit_count, miss_count, flush_start);
`else
      $display("[i_cache_dm] cyc=%0d state=%s addr=%h hit=%b flush_idx=%0d flush_start=%b",
               cycle_count, state.name(), i_mem_address_in, hit, flush_idx, flush_start);
`endif
    end
  end
`endif

endmodule

// File: tb/tb_i_cache_dm.sv
// -----------------------------------------------------------------------------
// tb_i_cache_dm
//   Self-checking bench for i_cache_dm (default geometry: 32-bit words,
//   32-bit word addresses, 64 lines). The bench plays backing memory with a
//   random-latency responder and keeps a line-level model of which address
//   each index currently holds.
// -----------------------------------------------------------------------------
module tb_i_cache_dm;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_mem_read;
  logic [31:0] i_mem_address_in;
  logic [31:0] i_mem_data_out;
  logic [31:0] i_mem_address_out;
  logic        i_mem_valid;
  logic        i_mem_ready;
  logic        mem_read;
  logic [31:0] mem_address_in;
  logic [31:0] mem_data_out;
  logic [31:0] mem_address_out;
  logic        mem_valid;
  logic        mem_ready;
  logic        flush;
  logic        scan;

  always #5 clock = ~clock;

  i_cache_dm dut (
    .clock             (clock),
    .reset             (reset),
    .i_mem_read        (i_mem_read),
    .i_mem_address_in  (i_mem_address_in),
    .i_mem_data_out    (i_mem_data_out),
    .i_mem_address_out (i_mem_address_out),
    .i_mem_valid       (i_mem_valid),
    .i_mem_ready       (i_mem_ready),
    .mem_read          (mem_read),
    .mem_address_in    (mem_address_in),
    .mem_data_out      (mem_data_out),
    .mem_address_out   (mem_address_out),
    .mem_valid         (mem_valid),
    .mem_ready         (mem_ready),
    .flush             (flush),
    .scan              (scan)
  );

  int tests_run = 0;
  int fails     = 0;

  // Reference model: which tag each index holds, if any.
  bit          model_v   [64];
  logic [25:0] model_tag [64];

  // Backing-memory responder state.
  bit          pend      = 1'b0;
  logic [31:0] pend_addr = '0;
  int          cnt       = 0;
  bit          auto_resp = 1'b1;
  bit          ready_low = 1'b0;
  bit          inj       = 1'b0;
  logic [31:0] inj_addr  = '0;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return model_v[a[5:0]] && (model_tag[a[5:0]] == a[31:6]);
  endfunction

  task automatic model_clear();
    foreach (model_v[i]) model_v[i] = 1'b0;
  endtask

  // Advance to the next falling edge, then play backing memory for the
  // coming rising edge.
  task automatic tick();
    @(negedge clock);
    mem_valid = 1'b0;
    if (inj) begin
      mem_valid       = 1'b1;
      mem_address_out = inj_addr;
      mem_data_out    = word(inj_addr);
      inj             = 1'b0;
    end else if (pend && auto_resp) begin
      if (cnt == 0) begin
        mem_valid       = 1'b1;
        mem_address_out = pend_addr;
        mem_data_out    = word(pend_addr);
        pend            = 1'b0;
      end else begin
        cnt--;
      end
    end
    mem_ready = ready_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    if (mem_read && mem_ready && !pend) begin
      pend      = 1'b1;
      pend_addr = mem_address_in;
      cnt       = $urandom_range(0, 2);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!i_mem_ready && n < 300) begin tick(); n++; end
    tests_run++;
    if (i_mem_ready !== 1'b1) begin
      fails++; $display("FAIL ready_timeout: i_mem_ready=%b required 1", i_mem_ready);
    end
  endtask

  // Issue one read, optionally stall memory acceptance, check the response.
  task automatic do_read(input logic [31:0] addr, input int stall);
    bit exp_hit, saw_rd, bad_addr, got, obs_hit;
    int k;
    wait_ready();
    exp_hit = model_hit(addr);
    if (stall > 0) ready_low = 1'b1;
    i_mem_read = 1'b1; i_mem_address_in = addr;
    tick();
    i_mem_read = 1'b0;
    for (int s = 0; s < stall; s++) begin
      tests_run++;
      if (mem_read !== 1'b1 || mem_address_in !== addr || i_mem_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold[%0d]: mem_read=%b addr=%h ready=%b required 1/%h/0",
                 s, mem_read, mem_address_in, i_mem_ready, addr);
      end
      tick();
    end
    ready_low = 1'b0;
    saw_rd = 0; bad_addr = 0; got = 0; k = 0;
    while (k < 300) begin
      if (mem_read) begin
        saw_rd = 1;
        if (mem_address_in !== addr) bad_addr = 1;
      end
      if (i_mem_valid) begin got = 1; break; end
      tick(); k++;
    end
    obs_hit = (k == 0) && !saw_rd;
    tests_run++;
    if (!got) begin
      fails++; $display("FAIL resp_timeout addr=%h: no i_mem_valid", addr);
    end
    tests_run++;
    if (i_mem_data_out !== word(addr) || i_mem_address_out !== addr) begin
      fails++;
      $display("FAIL resp_data addr=%h: got %h/%h required %h/%h",
               addr, i_mem_data_out, i_mem_address_out, word(addr), addr);
    end
    tests_run++;
    if (obs_hit !== exp_hit || bad_addr) begin
      fails++;
      $display("FAIL hit_miss addr=%h: hit=%b bad_mem_addr=%b required hit=%b",
               addr, obs_hit, bad_addr, exp_hit);
    end
    tick();
    tests_run++;
    if (i_mem_valid !== 1'b0) begin
      fails++; $display("FAIL valid_pulse addr=%h: i_mem_valid=%b required 0", addr, i_mem_valid);
    end
    model_v[addr[5:0]]   = 1'b1;
    model_tag[addr[5:0]] = addr[31:6];
  endtask

  // Flush from IDLE, optionally colliding with a read request.
  task automatic do_flush_idle(input bit with_read);
    int n, extra;
    wait_ready();
    flush = 1'b1; i_mem_read = with_read; i_mem_address_in = 32'h10;
    #1;
    tests_run++;
    if (i_mem_ready !== 1'b0) begin
      fails++; $display("FAIL flush_ready: i_mem_ready=%b required 0", i_mem_ready);
    end
    tick();
    flush = 1'b0; i_mem_read = 1'b0;
    n = 1; extra = (i_mem_valid || mem_read) ? 1 : 0;
    while (!i_mem_ready && n < 200) begin
      tick(); n++;
      if (i_mem_valid || mem_read) extra++;
    end
    tests_run++;
    if (n != 65 || extra != 0) begin
      fails++;
      $display("FAIL flush_sweep: %0d cycles with %0d stray outputs, required 65 and 0", n, extra);
    end
    model_clear();
  endtask

  // Issue a miss with the responder paused and return once it sits in FILL_WAIT.
  task automatic start_parked_miss(input logic [31:0] addr);
    int n = 0;
    auto_resp = 1'b0;
    wait_ready();
    i_mem_read = 1'b1; i_mem_address_in = addr;
    tick();
    i_mem_read = 1'b0;
    while (mem_read && n < 100) begin tick(); n++; end
    pend = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    tests_run++;
    if ({i_mem_valid, i_mem_data_out, i_mem_address_out, mem_read, mem_address_in, i_mem_ready} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%b data=%h addr=%h mem_read=%b mem_addr=%h ready=%b required all 0",
               i_mem_valid, i_mem_data_out, i_mem_address_out, mem_read, mem_address_in, i_mem_ready);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (i_mem_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready: i_mem_ready=%b required 1", i_mem_ready);
    end
    model_clear();
  endtask

  task automatic test_miss_hit();
    do_read(32'h10, 0);
    do_read(32'h10, 0);
  endtask

  task automatic test_alias();
    do_read(32'h50, 0);
    do_read(32'h10, 0);
    do_read(32'h10, 0);
  endtask

  task automatic test_stall();
    do_read(32'h20, 5);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) do_read(32'h100 + i, 0);
    wait_ready();
    i_mem_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_mem_address_in = 32'h100 + i;
      tick();
      tests_run++;
      if (i_mem_valid !== 1'b1 || i_mem_data_out !== word(32'h100 + i) ||
          i_mem_address_out !== 32'h100 + i) begin
        fails++;
        $display("FAIL b2b[%0d]: valid=%b data=%h addr=%h required 1/%h/%h", i,
                 i_mem_valid, i_mem_data_out, i_mem_address_out, word(32'h100 + i), 32'h100 + i);
      end
    end
    i_mem_read = 1'b0;
    tick();
  endtask

  task automatic test_flush_fill();
    int n, extra;
    start_parked_miss(32'h90);
    flush = 1'b1; tick(); flush = 1'b0;
    tick(); tick();
    tests_run++;
    if (i_mem_valid !== 1'b0) begin
      fails++; $display("FAIL early_resp: i_mem_valid=%b required 0", i_mem_valid);
    end
    inj = 1'b1; inj_addr = 32'h90;
    tick(); tick();
    tests_run++;
    if (i_mem_valid !== 1'b1 || i_mem_data_out !== word(32'h90) || i_mem_address_out !== 32'h90) begin
      fails++;
      $display("FAIL flush_fill_resp: valid=%b data=%h addr=%h required 1/%h/00000090",
               i_mem_valid, i_mem_data_out, i_mem_address_out, word(32'h90));
    end
    n = 0; extra = 0;
    while (!i_mem_ready && n < 200) begin
      tick(); n++;
      if (i_mem_valid) extra++;
    end
    tests_run++;
    if (n != 65 || extra != 0) begin
      fails++;
      $display("FAIL pending_sweep: %0d cycles with %0d stray valids, required 65 and 0", n, extra);
    end
    auto_resp = 1'b1;
    model_clear();
    do_read(32'h10, 0);
    do_read(32'h90, 0);
  endtask

  task automatic test_stale();
    int extra = 0;
    start_parked_miss(32'h10);
    inj = 1'b1; inj_addr = 32'h99;
    repeat (3) begin tick(); if (i_mem_valid) extra++; end
    tests_run++;
    if (extra != 0 || i_mem_ready !== 1'b0) begin
      fails++;
      $display("FAIL stale_ignored: %0d valids ready=%b required 0 and 0", extra, i_mem_ready);
    end
    inj = 1'b1; inj_addr = 32'h10;
    tick(); tick();
    tests_run++;
    if (i_mem_valid !== 1'b1 || i_mem_data_out !== 32'hDEADBEEF || i_mem_address_out !== 32'h10) begin
      fails++;
      $display("FAIL stale_then_match: valid=%b data=%h addr=%h required 1/deadbeef/00000010",
               i_mem_valid, i_mem_data_out, i_mem_address_out);
    end
    auto_resp = 1'b1;
    tick();
    model_v[6'h10] = 1'b1; model_tag[6'h10] = 26'h0;
    do_read(32'h10, 0);
  endtask

  task automatic test_reset_mid_fill();
    int extra = 0;
    start_parked_miss(32'h50);
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({i_mem_valid, i_mem_data_out, i_mem_address_out, mem_read, mem_address_in, i_mem_ready} !== '0) begin
      fails++;
      $display("FAIL reset_mid_fill: valid=%b data=%h addr=%h mem_read=%b mem_addr=%h ready=%b required all 0",
               i_mem_valid, i_mem_data_out, i_mem_address_out, mem_read, mem_address_in, i_mem_ready);
    end
    tick();
    reset = 1'b0;
    model_clear();
    inj = 1'b1; inj_addr = 32'h50;
    repeat (3) begin tick(); if (i_mem_valid || mem_read) extra++; end
    tests_run++;
    if (extra != 0) begin
      fails++; $display("FAIL late_resp_after_reset: %0d stray outputs required 0", extra);
    end
    auto_resp = 1'b1;
    do_read(32'h10, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 29) == 0) do_flush_idle(1'b0);
      else do_read((32'($urandom_range(0, 3)) << 6) | 32'($urandom_range(0, 7)), 0);
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    reset = 1'b1; i_mem_read = 1'b0; i_mem_address_in = '0;
    mem_data_out = '0; mem_address_out = '0; mem_valid = 1'b0; mem_ready = 1'b0;
    flush = 1'b0; scan = 1'b0;
    test_reset();
    test_miss_hit();
    test_alias();
    test_stall();
    test_back_to_back();
    do_flush_idle(1'b1);
    do_read(32'h10, 0);
    test_flush_fill();
    test_stale();
    test_reset_mid_fill();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
